// File: rtl/lio_i8080_disp_pkg.sv
// Shared opcodes, FSM states and constants for the i8080 display model.
package lio_i8080_disp_pkg;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_RDID    = 8'h04;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMRD   = 8'h2E;

  localparam logic [7:0] DUMMY_DATA  = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    CASET_SC,
    CASET_EC,
    PASET_SP,
    PASET_EP,
    RAMWR,
    RAMRD,
    RDID
  } state_e;

endpackage

// File: rtl/lio_i8080_bus_sync.sv
// Oversampling synchronizer for the async 8080 bus plus strobe edge detection.
// All bus signals share one pipeline so dc/d stay aligned with the strobes.
module lio_i8080_bus_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  dc,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic                  wr_evt,
  output logic                  rd_start,
  output logic                  rd_end,
  output logic                  conflict,
  output logic                  dc_s,
  output logic [DATA_WIDTH-1:0] d_s
);

  localparam int PW = DATA_WIDTH + 4;
  // Idle bus: ce/wr/rd high, so reset never fabricates an edge.
  localparam logic [PW-1:0] IDLE_W = {1'b1, 1'b0, 1'b1, 1'b1, {DATA_WIDTH{1'b0}}};

  logic [SYNC_STAGES-1:0][PW-1:0] pipe_q, pipe_d;
  logic [2:0]                     prev_q;
  logic                           wr_evt_q, rd_start_q, rd_end_q, conflict_q, dc_q;
  logic                           wr_evt_d, rd_start_d, rd_end_d, conflict_d;
  logic [DATA_WIDTH-1:0]          d_q;
  logic [PW-1:0]                  cur;
  logic                           c_ce, c_dc, c_wr, c_rd, p_ce, p_wr, p_rd;

  assign cur  = pipe_q[SYNC_STAGES-1];
  assign c_ce = cur[PW-1];
  assign c_dc = cur[PW-2];
  assign c_wr = cur[PW-3];
  assign c_rd = cur[PW-4];
  assign {p_ce, p_wr, p_rd} = prev_q;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {ce, dc, wr, rd, d_i};
    for (int i = 1; i < SYNC_STAGES; i++) pipe_d[i] = pipe_q[i-1];
    // A strobe edge is only honoured while the opposite strobe is idle high.
    wr_evt_d   = c_wr & ~p_wr & ~c_ce & c_rd & p_rd;
    rd_start_d = ~c_rd & p_rd & ~c_ce & c_wr;
    rd_end_d   = (c_rd & ~p_rd) | (c_ce & ~p_ce);
    conflict_d = (~c_wr & ~c_rd & ~c_ce) & ~(~p_wr & ~p_rd & ~p_ce);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q     <= {SYNC_STAGES{IDLE_W}};
      prev_q     <= 3'b111;
      wr_evt_q   <= 1'b0;
      rd_start_q <= 1'b0;
      rd_end_q   <= 1'b0;
      conflict_q <= 1'b0;
      dc_q       <= 1'b0;
      d_q        <= '0;
    end else begin
      pipe_q     <= pipe_d;
      prev_q     <= {c_ce, c_wr, c_rd};
      wr_evt_q   <= wr_evt_d;
      rd_start_q <= rd_start_d;
      rd_end_q   <= rd_end_d;
      conflict_q <= conflict_d;
      dc_q       <= c_dc;
      d_q        <= cur[DATA_WIDTH-1:0];
    end
  end

  assign wr_evt   = wr_evt_q;
  assign rd_start = rd_start_q;
  assign rd_end   = rd_end_q;
  assign conflict = conflict_q;
  assign dc_s     = dc_q;
  assign d_s      = d_q;

endmodule

// File: rtl/lio_i8080_display_model.sv
// Clocked i8080 windowed-framebuffer display model (CASET/PASET/RAMWR/RAMRD/RDID).
// Define LIO_I8080_DISP_DUMMY_RD_EN to return a dummy word on the first RAMRD read.
module lio_i8080_display_model
  import lio_i8080_disp_pkg::*;
#(
  parameter int                        DATA_WIDTH  = 8,
  parameter int                        COLS        = 16,
  parameter int                        ROWS        = 16,
  parameter logic [DATA_WIDTH-1:0]     ID_VALUE    = 'h93,
  parameter int                        SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ce,
  input  logic                          dc,
  input  logic                          wr,
  input  logic                          rd,
  input  logic [DATA_WIDTH-1:0]         d_i,
  output logic [DATA_WIDTH-1:0]         d_o,
  output logic                          d_oe,
  output logic                          frame_done,
  output logic [7:0]                    err_cnt,
  input  logic [$clog2(COLS*ROWS)-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0]         dbg_data
);

  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW    = $clog2(COLS*ROWS);
  localparam int DEPTH = COLS * ROWS;

  logic                  wr_evt, rd_start, rd_end, conflict, dc_s;
  logic [DATA_WIDTH-1:0] d_s;

  lio_i8080_bus_sync #(.DATA_WIDTH(DATA_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .ce(ce), .dc(dc), .wr(wr), .rd(rd), .d_i(d_i),
    .wr_evt(wr_evt), .rd_start(rd_start), .rd_end(rd_end), .conflict(conflict),
    .dc_s(dc_s), .d_s(d_s)
  );

  state_e                state_q, state_d;
  logic [CW-1:0]         sc_q, sc_d, ec_q, ec_d, col_q, col_d, nxt_col, d_col;
  logic [RW-1:0]         sp_q, sp_d, ep_q, ep_d, page_q, page_d, nxt_page, d_row;
  logic [DATA_WIDTH-1:0] d_o_q, d_o_d, dbg_data_q;
  logic                  d_oe_q, d_oe_d, frame_done_q, frame_done_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  err_inc, wrap, ram_we;
  logic [AW-1:0]         ptr_addr;
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
  logic                  dummy_q, dummy_d;
`endif

  assign ptr_addr = AW'(page_q) * AW'(COLS) + AW'(col_q);
  assign d_col    = (d_s > DATA_WIDTH'(COLS-1)) ? CW'(COLS-1) : d_s[CW-1:0];
  assign d_row    = (d_s > DATA_WIDTH'(ROWS-1)) ? RW'(ROWS-1) : d_s[RW-1:0];

  // Shared write/read pointer walk: column first, then page, wrapping the window.
  always_comb begin
    nxt_col  = col_q + CW'(1);
    nxt_page = page_q;
    wrap     = 1'b0;
    if (col_q == ec_q) begin
      nxt_col = sc_q;
      if (page_q == ep_q) begin
        nxt_page = sp_q;
        wrap     = 1'b1;
      end else begin
        nxt_page = page_q + RW'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    ec_d         = ec_q;
    sp_d         = sp_q;
    ep_d         = ep_q;
    col_d        = col_q;
    page_d       = page_q;
    d_o_d        = d_o_q;
    d_oe_d       = d_oe_q;
    frame_done_d = 1'b0;
    err_inc      = conflict;
    ram_we       = 1'b0;
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
    dummy_d      = dummy_q;
`endif

    if (wr_evt && !dc_s) begin
      state_d = IDLE;
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
      dummy_d = 1'b0;
`endif
      case (d_s)
        DATA_WIDTH'(CMD_NOP): ;
        DATA_WIDTH'(CMD_SWRESET): begin
          sc_d   = '0;
          ec_d   = CW'(COLS-1);
          sp_d   = '0;
          ep_d   = RW'(ROWS-1);
          col_d  = '0;
          page_d = '0;
          d_o_d  = '0;
          d_oe_d = 1'b0;
        end
        DATA_WIDTH'(CMD_CASET): state_d = CASET_SC;
        DATA_WIDTH'(CMD_PASET): state_d = PASET_SP;
        DATA_WIDTH'(CMD_RAMWR): begin
          state_d = RAMWR;
          col_d   = sc_q;
          page_d  = sp_q;
        end
        DATA_WIDTH'(CMD_RAMRD): begin
          state_d = RAMRD;
          col_d   = sc_q;
          page_d  = sp_q;
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
          dummy_d = 1'b1;
`endif
        end
        DATA_WIDTH'(CMD_RDID): state_d = RDID;
        default: err_inc = 1'b1;
      endcase
    end else if (wr_evt) begin
      case (state_q)
        CASET_SC: begin sc_d = d_col; state_d = CASET_EC; end
        CASET_EC: begin ec_d = (d_col < sc_q) ? sc_q : d_col; state_d = IDLE; end
        PASET_SP: begin sp_d = d_row; state_d = PASET_EP; end
        PASET_EP: begin ep_d = (d_row < sp_q) ? sp_q : d_row; state_d = IDLE; end
        RAMWR: begin
          ram_we       = 1'b1;
          col_d        = nxt_col;
          page_d       = nxt_page;
          frame_done_d = wrap;
        end
        default: err_inc = 1'b1;
      endcase
    end

    if (rd_start) begin
      d_oe_d = 1'b1;
      case (state_q)
        RAMRD: begin
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
          if (dummy_q) begin
            d_o_d   = DATA_WIDTH'(DUMMY_DATA);
            dummy_d = 1'b0;
          end else begin
            d_o_d  = ram_q[ptr_addr];
            col_d  = nxt_col;
            page_d = nxt_page;
          end
`else
          d_o_d  = ram_q[ptr_addr];
          col_d  = nxt_col;
          page_d = nxt_page;
`endif
        end
        RDID: d_o_d = ID_VALUE;
        default: begin
          d_o_d   = DATA_WIDTH'(DUMMY_DATA);
          err_inc = 1'b1;
        end
      endcase
    end else if (rd_end) begin
      d_oe_d = 1'b0;
    end

    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sc_q         <= '0;
      ec_q         <= CW'(COLS-1);
      sp_q         <= '0;
      ep_q         <= RW'(ROWS-1);
      col_q        <= '0;
      page_q       <= '0;
      d_o_q        <= '0;
      d_oe_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= '0;
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
      dummy_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sc_q         <= sc_d;
      ec_q         <= ec_d;
      sp_q         <= sp_d;
      ep_q         <= ep_d;
      col_q        <= col_d;
      page_q       <= page_d;
      d_o_q        <= d_o_d;
      d_oe_q       <= d_oe_d;
      frame_done_q <= frame_done_d;
      err_cnt_q    <= err_cnt_d;
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
      dummy_q      <= dummy_d;
`endif
    end
  end

  // Framebuffer is never reset, so it can map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ptr_addr] <= d_s;
    dbg_data_q <= ram_q[dbg_addr];
  end

  assign d_o        = d_o_q;
  assign d_oe       = d_oe_q;
  assign frame_done = frame_done_q;
  assign err_cnt    = err_cnt_q;
  assign dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_lio_i8080_display_model.sv
// Directed scoreboard bench for lio_i8080_display_model (default parameters).
module tb_lio_i8080_display_model;

  logic       clk = 1'b0;
  logic       rst_n, ce, dc, wr, rd;
  logic [7:0] d_i, d_o, dbg_data, err_cnt, dbg_addr;
  logic       d_oe, frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [31:0] sb[$];

  lio_i8080_display_model dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .dc(dc), .wr(wr), .rd(rd), .d_i(d_i),
    .d_o(d_o), .d_oe(d_oe), .frame_done(frame_done), .err_cnt(err_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, sb.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bwr(input logic c, input logic [7:0] v);
    dc  = c;
    d_i = v;
    ce  = 1'b0;
    wr  = 1'b0;
    idle(6);
    wr  = 1'b1;
    idle(6);
  endtask

  task automatic brd(input string tag);
    rd = 1'b0;
    idle(6);
    chk({tag, "_oe_hi"}, 32'(d_oe), 32'd1);
    sb_pop(tag, 32'(d_o));
    rd = 1'b1;
    idle(6);
    chk({tag, "_oe_lo"}, 32'(d_oe), 32'd0);
  endtask

  task automatic dbg(input string tag, input logic [7:0] a);
    dbg_addr = a;
    idle(2);
    sb_pop(tag, 32'(dbg_data));
  endtask

  initial begin
    int fd0;
    rst_n = 1'b0; ce = 1'b1; dc = 1'b0; wr = 1'b1; rd = 1'b1;
    d_i = '0; dbg_addr = '0;
    idle(3);
    chk("rst_d_o", 32'(d_o), 32'd0);
    chk("rst_d_oe", 32'(d_oe), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Plain RAMWR from reset window
    bwr(1'b0, 8'h2C);
    for (int i = 0; i < 4; i++) bwr(1'b1, 8'(8'h11 + i));
    for (int i = 0; i < 4; i++) begin
      sb.push_back(32'(8'h11 + i));
      dbg("ramwr_basic", 8'(i));
    end
    chk("err_after_basic", 32'(err_cnt), 32'd0);

    // Windowed write with wrap and frame_done
    bwr(1'b0, 8'h2A); bwr(1'b1, 8'd2); bwr(1'b1, 8'd3);
    bwr(1'b0, 8'h2B); bwr(1'b1, 8'd1); bwr(1'b1, 8'd2);
    bwr(1'b0, 8'h2C);
    fd0 = fd_cnt;
    for (int i = 0; i < 5; i++) begin
      bwr(1'b1, 8'(8'hA0 + i));
      chk("frame_done_cnt", 32'(fd_cnt - fd0), (i >= 3) ? 32'd1 : 32'd0);
    end
    sb.push_back(32'hA4); dbg("win18", 8'd18);
    sb.push_back(32'hA1); dbg("win19", 8'd19);
    sb.push_back(32'hA2); dbg("win34", 8'd34);
    sb.push_back(32'hA3); dbg("win35", 8'd35);

    // SWRESET restores full window; fill then read back
    bwr(1'b0, 8'h01);
    bwr(1'b0, 8'h2C);
    for (int i = 0; i < 4; i++) bwr(1'b1, 8'(i));
    bwr(1'b0, 8'h2E);
`ifdef LIO_I8080_DISP_DUMMY_RD_EN
    sb.push_back(32'hEB);
    brd("ramrd_dummy");
`endif
    for (int i = 0; i < 4; i++) begin
      sb.push_back(32'(i));
      brd("ramrd");
    end
    chk("d_o_hold", 32'(d_o), 32'd3);

    // RDID and read in IDLE
    bwr(1'b0, 8'h04);
    sb.push_back(32'h93);
    brd("rdid");
    chk("err_before_idle_rd", 32'(err_cnt), 32'd0);
    bwr(1'b0, 8'h00);
    sb.push_back(32'hEB);
    brd("idle_rd");
    chk("err_idle_rd", 32'(err_cnt), 32'd1);

    // CASET clamp: 20,5 -> SC=EC=15
    bwr(1'b0, 8'h2A); bwr(1'b1, 8'd20); bwr(1'b1, 8'd5);
    bwr(1'b0, 8'h2C); bwr(1'b1, 8'h5A); bwr(1'b1, 8'h5B);
    sb.push_back(32'h5A); dbg("clamp15", 8'd15);
    sb.push_back(32'h5B); dbg("clamp31", 8'd31);
    chk("err_after_clamp", 32'(err_cnt), 32'd1);
    bwr(1'b0, 8'h55);
    chk("err_bad_op", 32'(err_cnt), 32'd2);

    // Reset in the middle of PASET
    bwr(1'b0, 8'h2B); bwr(1'b1, 8'd3);
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_d_o", 32'(d_o), 32'd0);
    rst_n = 1'b1;
    idle(3);
    bwr(1'b0, 8'h2C); bwr(1'b1, 8'h77); bwr(1'b1, 8'h78);
    sb.push_back(32'h77); dbg("post_rst0", 8'd0);
    sb.push_back(32'h78); dbg("post_rst1", 8'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
